// File: rtl/mem_io_pkg.sv
// Shared types and address-field layout for the CPU data-side memory/IO bridge.
// Pure definitions: no latency, no backpressure.
package mem_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEM     = 2'd1,
        ST_IO_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    localparam int MAX_DATA_W = 256;
    localparam logic [MAX_DATA_W-1:0] ERR_DATA = '1;

    // IO address layout: window above bit 10, channel in [7:4], register offset in [3:0]
    localparam int WIN_LSB = 10;
    localparam int CH_LSB  = 4;
    localparam int CH_W    = 4;
    localparam int OFF_LSB = 0;
    localparam int OFF_W   = 4;

    function automatic logic in_io_window(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:WIN_LSB] == base[31:WIN_LSB];
    endfunction

endpackage

// File: rtl/mem_io_timeout.sv
// Loadable down-counter bounding the IO ack wait; expired is high while the count is zero.
// Single-cycle update; clear has priority over load, load over decrement.
module mem_io_timeout #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             clr,
    input  logic             en,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/mem_io_bridge.sv
// Load/store bridge to data memory and N one-hot IO channels with ack timeout.
// Memory: response 2 cycles after accept; IO: waits on ack or timeout; req_ready only in IDLE.
module mem_io_bridge
    import mem_io_pkg::*;
#(
    parameter int          DATA_W  = 32,
    parameter int          N_CH    = 4,
    parameter logic [31:0] IO_BASE = 32'hFFFF_FC00,
    parameter int          IO_RD_W = 16,
    parameter int          IO_SEXT = 1,
    parameter int          TIMEOUT = 15
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic                    req_write,
    input  logic [31:0]             req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    input  logic [DATA_W/8-1:0]     req_be,
    output logic                    req_ready,
    output logic                    rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic                    mem_cs,
    output logic                    mem_we,
    output logic [31:0]             mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic [DATA_W/8-1:0]     mem_be,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [N_CH-1:0]         io_cs,
    output logic                    io_we,
    output logic [OFF_W-1:0]        io_off,
    output logic [DATA_W-1:0]       io_wdata,
    input  logic [N_CH*IO_RD_W-1:0] io_rdata,
    input  logic [N_CH-1:0]         io_ack,
    output logic                    err_sticky
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic                write_q, write_d;
    logic                req_ready_q, req_ready_d;
    logic                mem_cs_q, mem_cs_d;
    logic                mem_we_q, mem_we_d;
    logic [N_CH-1:0]     io_cs_q, io_cs_d;
    logic                io_we_q, io_we_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_mem_q, rsp_mem_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_sticky_q, err_sticky_d;

    logic [CH_W-1:0]     acc_ch;
    logic                acc_ch_ok;
    logic [N_CH-1:0]     acc_onehot;
    logic                ack_sel;
    logic [IO_RD_W-1:0]  io_slice;
    logic [DATA_W-1:0]   io_ext;
    logic [DATA_W-1:0]   mem_mask;
    logic                tmo_load, tmo_clr, tmo_en, tmo_exp;

    assign acc_ch    = req_addr[CH_LSB +: CH_W];
    assign acc_ch_ok = int'(acc_ch) < N_CH;
    assign ack_sel   = |(io_ack & io_cs_q);

    always_comb begin
        acc_onehot = '0;
        for (int c = 0; c < N_CH; c++) begin
            acc_onehot[c] = (int'(acc_ch) == c);
        end
    end

    // The held one-hot select doubles as the read-data mux control
    always_comb begin
        io_slice = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (io_cs_q[c]) begin
                io_slice = io_rdata[c*IO_RD_W +: IO_RD_W];
            end
        end
        io_ext = (IO_SEXT != 0) ? DATA_W'(signed'(io_slice)) : DATA_W'(io_slice);
    end

    always_comb begin
        mem_mask = '0;
        for (int b = 0; b < BE_W; b++) begin
            mem_mask[b*8 +: 8] = {8{be_q[b]}};
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        write_d      = write_q;
        mem_cs_d     = 1'b0;
        mem_we_d     = 1'b0;
        io_cs_d      = '0;
        io_we_d      = 1'b0;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = 1'b0;
        rsp_mem_d    = 1'b0;
        rdata_d      = '0;
        tmo_load     = 1'b0;
        tmo_clr      = 1'b0;
        tmo_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    write_d = req_write;
                    if (!in_io_window(req_addr, IO_BASE)) begin
                        state_d  = ST_MEM;
                        mem_cs_d = 1'b1;
                        mem_we_d = req_write;
                    end else if (acc_ch_ok) begin
                        state_d  = ST_IO_WAIT;
                        io_cs_d  = acc_onehot;
                        io_we_d  = req_write;
                        tmo_load = 1'b1;
                    end else begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rdata_d     = ERR_DATA[DATA_W-1:0];
                    end
                end
            end
            ST_MEM: begin
                // Load data arrives from memory during RESP and is masked on the way out
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_mem_d   = !write_q;
            end
            ST_IO_WAIT: begin
                if (ack_sel) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rdata_d     = write_q ? '0 : io_ext;
                    tmo_clr     = 1'b1;
                end else if (tmo_exp) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rdata_d     = ERR_DATA[DATA_W-1:0];
                    tmo_clr     = 1'b1;
                end else begin
                    io_cs_d = io_cs_q;
                    io_we_d = io_we_q;
                    tmo_en  = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d  = (state_d == ST_IDLE);
        err_sticky_d = err_sticky_q | (rsp_valid_q & rsp_err_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            write_q      <= 1'b0;
            req_ready_q  <= 1'b1;
            mem_cs_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            io_cs_q      <= '0;
            io_we_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_mem_q    <= 1'b0;
            rdata_q      <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            write_q      <= write_d;
            req_ready_q  <= req_ready_d;
            mem_cs_q     <= mem_cs_d;
            mem_we_q     <= mem_we_d;
            io_cs_q      <= io_cs_d;
            io_we_q      <= io_we_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_mem_q    <= rsp_mem_d;
            rdata_q      <= rdata_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    mem_io_timeout #(
        .CNT_W (CNT_W)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .load     (tmo_load),
        .load_val (CNT_W'(TIMEOUT - 1)),
        .clr      (tmo_clr),
        .en       (tmo_en),
        .expired  (tmo_exp)
    );

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_rdata  = rsp_mem_q ? (mem_rdata & mem_mask) : rdata_q;
    assign mem_cs     = mem_cs_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_be     = be_q;
    assign io_cs      = io_cs_q;
    assign io_we      = io_we_q;
    assign io_off     = addr_q[OFF_LSB +: OFF_W];
    assign io_wdata   = wdata_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench: bridge A has 8 channels with sign extension, bridge B 4 channels with zero extension.
module tb_mem_io_bridge;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid_a = 1'b0, req_valid_b = 1'b0;
    logic         req_write = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [31:0]  req_wdata = '0;
    logic [3:0]   req_be = '0;
    logic [31:0]  mem_rdata = '0;
    logic [127:0] io_rdata_a = '0;
    logic [63:0]  io_rdata_b = '0;
    logic [7:0]   io_ack_a = '0;
    logic [3:0]   io_ack_b = '0;

    logic         req_ready_a, rsp_valid_a, rsp_err_a, mem_cs_a, mem_we_a, io_we_a, err_sticky_a;
    logic [31:0]  rsp_rdata_a, mem_addr_a, mem_wdata_a, io_wdata_a;
    logic [3:0]   mem_be_a, io_off_a;
    logic [7:0]   io_cs_a;

    logic         req_ready_b, rsp_valid_b, rsp_err_b, mem_cs_b, mem_we_b, io_we_b, err_sticky_b;
    logic [31:0]  rsp_rdata_b, mem_addr_b, mem_wdata_b, io_wdata_b;
    logic [3:0]   mem_be_b, io_off_b;
    logic [3:0]   io_cs_b;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    mem_io_bridge #(.DATA_W(32), .N_CH(8), .IO_BASE(32'hFFFF_FC00), .IO_RD_W(16),
                    .IO_SEXT(1), .TIMEOUT(15)) dut_a (
        .clock(clock), .reset(reset),
        .req_valid(req_valid_a), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be), .req_ready(req_ready_a),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
        .mem_cs(mem_cs_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_be(mem_be_a), .mem_rdata(mem_rdata),
        .io_cs(io_cs_a), .io_we(io_we_a), .io_off(io_off_a), .io_wdata(io_wdata_a),
        .io_rdata(io_rdata_a), .io_ack(io_ack_a), .err_sticky(err_sticky_a)
    );

    mem_io_bridge #(.DATA_W(32), .N_CH(4), .IO_BASE(32'hFFFF_FC00), .IO_RD_W(16),
                    .IO_SEXT(0), .TIMEOUT(15)) dut_b (
        .clock(clock), .reset(reset),
        .req_valid(req_valid_b), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be), .req_ready(req_ready_b),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
        .mem_cs(mem_cs_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_be(mem_be_b), .mem_rdata(mem_rdata),
        .io_cs(io_cs_b), .io_we(io_we_b), .io_off(io_off_b), .io_wdata(io_wdata_b),
        .io_rdata(io_rdata_b), .io_ack(io_ack_b), .err_sticky(err_sticky_b)
    );

    task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Presents one request for a single cycle; returns at the negedge of cycle k+1
    task automatic send(input bit to_b, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        @(negedge clock);
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        if (to_b) req_valid_b = 1'b1;
        else      req_valid_a = 1'b1;
        @(negedge clock);
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        step();
        chk_vec("rst_ready", 32'(req_ready_a), 32'd1);
        chk_vec("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
        chk_vec("rst_mem_cs", 32'(mem_cs_a), 32'd0);
        chk_vec("rst_io_cs", 32'(io_cs_a), 32'd0);
        chk_vec("rst_sticky", 32'(err_sticky_a), 32'd0);
        chk_vec("rst_rdata", rsp_rdata_a, 32'd0);

        // Memory load, full word
        send(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
        mem_rdata = 32'h1234_5678;
        chk_vec("mld_cs", 32'(mem_cs_a), 32'd1);
        chk_vec("mld_we", 32'(mem_we_a), 32'd0);
        chk_vec("mld_addr", mem_addr_a, 32'h0000_0010);
        chk_vec("mld_be", 32'(mem_be_a), 32'hF);
        chk_vec("mld_early_rsp", 32'(rsp_valid_a), 32'd0);
        chk_vec("mld_busy", 32'(req_ready_a), 32'd0);
        step();
        chk_vec("mld_rsp", 32'(rsp_valid_a), 32'd1);
        chk_vec("mld_data", rsp_rdata_a, 32'h1234_5678);
        chk_vec("mld_err", 32'(rsp_err_a), 32'd0);
        chk_vec("mld_cs_drop", 32'(mem_cs_a), 32'd0);
        step();
        chk_vec("mld_ready", 32'(req_ready_a), 32'd1);
        chk_vec("mld_rsp_end", 32'(rsp_valid_a), 32'd0);

        // Memory load with partial byte enables
        send(0, 1'b0, 32'h0000_0020, 32'h0, 4'b0101);
        step();
        chk_vec("mbe_data", rsp_rdata_a, 32'h0034_0078);
        step();

        // Memory store
        send(0, 1'b1, 32'h0000_0040, 32'h55AA_0FF0, 4'hF);
        chk_vec("mst_we", 32'(mem_we_a), 32'd1);
        chk_vec("mst_wdata", mem_wdata_a, 32'h55AA_0FF0);
        step();
        chk_vec("mst_rsp", 32'(rsp_valid_a), 32'd1);
        chk_vec("mst_data", rsp_rdata_a, 32'd0);
        step();

        // IO store to channel 6, stray ack on ch5, real ack in cycle k+4
        send(0, 1'b1, 32'hFFFF_FC6C, 32'hAABB_CCDD, 4'hF);
        chk_vec("ist_cs1", 32'(io_cs_a), 32'h40);
        chk_vec("ist_we", 32'(io_we_a), 32'd1);
        chk_vec("ist_wdata", io_wdata_a, 32'hAABB_CCDD);
        chk_vec("ist_off", 32'(io_off_a), 32'hC);
        chk_vec("ist_no_mem", 32'(mem_cs_a), 32'd0);
        io_ack_a = 8'h20;
        step();
        io_ack_a = 8'h00;
        chk_vec("ist_cs2", 32'(io_cs_a), 32'h40);
        chk_vec("ist_stray_ack", 32'(rsp_valid_a), 32'd0);
        step();
        chk_vec("ist_cs3", 32'(io_cs_a), 32'h40);
        step();
        chk_vec("ist_cs4", 32'(io_cs_a), 32'h40);
        io_ack_a = 8'h40;
        step();
        io_ack_a = 8'h00;
        chk_vec("ist_rsp", 32'(rsp_valid_a), 32'd1);
        chk_vec("ist_data", rsp_rdata_a, 32'd0);
        chk_vec("ist_err", 32'(rsp_err_a), 32'd0);
        chk_vec("ist_cs_drop", 32'(io_cs_a), 32'd0);
        step();

        // IO load ch1, immediate ack, sign- and zero-extension
        io_rdata_a[31:16] = 16'h8001;
        io_rdata_b[31:16] = 16'h8001;
        send(0, 1'b0, 32'hFFFF_FC10, 32'h0, 4'hF);
        chk_vec("ild_cs_a", 32'(io_cs_a), 32'h02);
        chk_vec("ild_we_a", 32'(io_we_a), 32'd0);
        io_ack_a = 8'h02;
        step();
        io_ack_a = 8'h00;
        chk_vec("ild_rsp_a", 32'(rsp_valid_a), 32'd1);
        chk_vec("ild_sext", rsp_rdata_a, 32'hFFFF_8001);
        step();
        send(1, 1'b0, 32'hFFFF_FC10, 32'h0, 4'hF);
        chk_vec("ild_cs_b", 32'(io_cs_b), 32'h2);
        io_ack_b = 4'h2;
        step();
        io_ack_b = 4'h0;
        chk_vec("ild_rsp_b", 32'(rsp_valid_b), 32'd1);
        chk_vec("ild_zext", rsp_rdata_b, 32'h0000_8001);
        step();
        chk_vec("sticky_clean", 32'(err_sticky_a), 32'd0);

        // IO load ch2 with no ack: timeout
        send(0, 1'b0, 32'hFFFF_FC20, 32'h0, 4'hF);
        for (int i = 1; i <= 15; i++) begin
            chk_vec($sformatf("tmo_wait%0d", i), 32'(rsp_valid_a), 32'd0);
            chk_vec($sformatf("tmo_cs%0d", i), 32'(io_cs_a), 32'h04);
            step();
        end
        chk_vec("tmo_rsp", 32'(rsp_valid_a), 32'd1);
        chk_vec("tmo_err", 32'(rsp_err_a), 32'd1);
        chk_vec("tmo_data", rsp_rdata_a, 32'hFFFF_FFFF);
        chk_vec("tmo_cs_drop", 32'(io_cs_a), 32'd0);
        step();
        chk_vec("tmo_sticky", 32'(err_sticky_a), 32'd1);
        chk_vec("tmo_rsp_end", 32'(rsp_valid_a), 32'd0);

        // Same, with ack in the final wait cycle: ack wins
        io_rdata_a[47:32] = 16'h1234;
        send(0, 1'b0, 32'hFFFF_FC20, 32'h0, 4'hF);
        for (int i = 1; i <= 15; i++) begin
            if (i == 15) io_ack_a = 8'h04;
            chk_vec($sformatf("lack_wait%0d", i), 32'(rsp_valid_a), 32'd0);
            step();
        end
        io_ack_a = 8'h00;
        chk_vec("lack_rsp", 32'(rsp_valid_a), 32'd1);
        chk_vec("lack_err", 32'(rsp_err_a), 32'd0);
        chk_vec("lack_data", rsp_rdata_a, 32'h0000_1234);
        step();
        chk_vec("lack_sticky", 32'(err_sticky_a), 32'd1);

        // Unmapped channel 15 on the 4-channel bridge
        send(1, 1'b0, 32'hFFFF_FCF0, 32'h0, 4'hF);
        chk_vec("unm_rsp", 32'(rsp_valid_b), 32'd1);
        chk_vec("unm_err", 32'(rsp_err_b), 32'd1);
        chk_vec("unm_data", rsp_rdata_b, 32'hFFFF_FFFF);
        chk_vec("unm_io_cs", 32'(io_cs_b), 32'd0);
        chk_vec("unm_mem_cs", 32'(mem_cs_b), 32'd0);
        step();
        chk_vec("unm_sticky", 32'(err_sticky_b), 32'd1);
        chk_vec("unm_io_cs2", 32'(io_cs_b), 32'd0);
        chk_vec("unm_ready", 32'(req_ready_b), 32'd1);

        // Reset during the second IO wait cycle
        send(0, 1'b0, 32'hFFFF_FC30, 32'h0, 4'hF);
        chk_vec("mrst_cs1", 32'(io_cs_a), 32'h08);
        step();
        chk_vec("mrst_cs2", 32'(io_cs_a), 32'h08);
        #1 reset = 1'b1;
        #1 chk_vec("mrst_cs_async", 32'(io_cs_a), 32'd0);
        step();
        reset = 1'b0;
        io_ack_a = 8'h08;
        for (int i = 0; i < 3; i++) begin
            step();
            io_ack_a = 8'h00;
            chk_vec($sformatf("mrst_no_rsp%0d", i), 32'(rsp_valid_a), 32'd0);
        end
        chk_vec("mrst_ready", 32'(req_ready_a), 32'd1);
        chk_vec("mrst_sticky", 32'(err_sticky_a), 32'd0);
        chk_vec("mrst_io_cs", 32'(io_cs_a), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
